cpu_debug_ctrl: RTL and testbench
=================================

Name: cpu_debug_ctrl

Overview:
Parametrised run/step/breakpoint controller and debug display selector for the multicycle CPU. It debounces the board keys and generates a single-cycle CPU clock enable (cpu_ce) in free-run, single-step or halted modes, with a PC breakpoint. It also multiplexes NCH debug channels onto the HEX display data path. It replaces the fixed slow-clock divider and two-way display mux at the CPU top level. Everything runs on one clock, and the CPU datapath is qualified by cpu_ce.

Parameters:
DIV_W, 23, run-mode tick period is 2^DIV_W clk cycles
DBNC_W, 16, debounce window is 2^DBNC_W stable clk cycles
NCH, 4, number of display channels (>=2)
DATA_W, 16, display channel width
PC_W, 16, program counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
key_mode_n  in  1  raw async key, active-low; toggles run/halt
key_step_n  in  1  raw async key, active-low; single step while halted
key_sel_n  in  1  raw async key, active-low; advances display channel
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
pc  in  PC_W  current CPU PC
ch_data  in  NCH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
cpu_ce  out  1  one-cycle CPU advance pulse
run  out  1  1 while in RUN state
halted_on_bp  out  1  sticky: halted by breakpoint
disp_sel  out  max(1,$clog2(NCH))  current display channel
disp_data  out  DATA_W  registered selected channel data
heartbeat  out  1  MSB of free-running DIV_W+1-bit counter

Behaviour:
- Reset: state HALT; cpu_ce, run, halted_on_bp, disp_sel, disp_data and heartbeat are all 0; div and heartbeat counters are 0; debounced levels are 1 (released); bp_skip is 0. Reset mid-operation aborts any pending tick or step.
- Key input path:
  - Each key passes through a 2-flop synchroniser, then a debouncer.
  - The debouncer counter resets whenever the synchronised value equals the debounced level.
  - When the values differ for 2^DBNC_W consecutive cycles, the debounced level flips.
  - A press event is a one-cycle pulse on a debounced 1->0 transition. Releases generate no event.
- FSM states: HALT, STEP, RUN.
  - HALT: a mode press goes to RUN, clears div, sets bp_skip and clears halted_on_bp. Otherwise a step press goes to STEP and clears halted_on_bp. If both presses occur in the same cycle, mode wins and the step press is dropped.
  - STEP: cpu_ce=1 for exactly this one cycle; the next state is HALT. The breakpoint is ignored, so a step can leave a breakpoint PC. Presses arriving during STEP are dropped.
  - RUN: div increments every cycle. A tick occurs when div is all ones; div then wraps to 0.
    - On a tick with bp_en=1, pc==bp_addr and bp_skip=0: cpu_ce stays 0, the next state is HALT, and halted_on_bp is set to 1.
    - On any other tick: cpu_ce=1, and bp_skip clears.
    - A mode press in RUN goes to HALT, clears div and suppresses any coincident tick.
    - Step presses in RUN are ignored.
- Outputs:
  - cpu_ce is registered and never high for two consecutive cycles.
  - run = (state==RUN).
  - First cpu_ce after entering RUN: 2^DIV_W cycles after the mode-press event cycle.
- Display:
  - A sel press sets disp_sel <= (disp_sel==NCH-1) ? 0 : disp_sel+1. This works in every FSM state.
  - disp_data <= ch_data slice[disp_sel] every cycle, giving 1-cycle latency from a ch_data change.
  - After a disp_sel change, the new channel appears on disp_data one cycle later.
- heartbeat: free-running counter, independent of FSM state; cleared only by rst.

Test Plan:
1. DIV_W=3, DBNC_W=2. Reset, then mode press held 10 cycles -> press event ~6 cycles after assertion; run=1; cpu_ce pulses every 8 cycles, first pulse 8 cycles after the event. A 2-cycle glitch on the key produces no event.
2. In HALT, press step 3 times -> exactly 3 cpu_ce pulses, each 1 cycle wide; run stays 0. Step presses while in RUN -> no extra cpu_ce.
3. bp_en=1, bp_addr=0x0005, pc increments on each cpu_ce from 0x0000 -> 5 pulses, then halt with pc=0x0005, halted_on_bp=1. A mode press then resumes, the next tick fires cpu_ce (skip), and halted_on_bp=0.
4. In HALT at the breakpoint, a step press -> cpu_ce=1 and halted_on_bp=0. Mode and step pressed in the same cycle -> RUN entered with no STEP pulse.
5. NCH=4, ch_data={0xDDDD,0xCCCC,0xBBBB,0xAAAA}. Sel presses x5 -> disp_sel sequence 1,2,3,0,1 and disp_data 0xBBBB,0xCCCC,0xDDDD,0xAAAA,0xBBBB, each appearing 1 cycle after the disp_sel change.
6. Assert rst mid-RUN just before a tick -> no cpu_ce; all outputs 0; state HALT; disp_sel=0.

Source files
------------

// File: rtl/cpu_debug_ctrl.sv
// Run/step/breakpoint controller for the multicycle CPU: debounces the board keys,
// issues a one-cycle cpu_ce and drives an NCH-way registered debug display selector.
module cpu_debug_ctrl #(
    parameter int DIV_W  = 23,
    parameter int DBNC_W = 16,
    parameter int NCH    = 4,
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_mode_n,
    input  logic                  key_step_n,
    input  logic                  key_sel_n,
    input  logic                  bp_en,
    input  logic [PC_W-1:0]       bp_addr,
    input  logic [PC_W-1:0]       pc,
    input  logic [NCH*DATA_W-1:0] ch_data,
    output logic                  cpu_ce,
    output logic                  run,
    output logic                  halted_on_bp,
    output logic [SEL_W-1:0]      disp_sel,
    output logic [DATA_W-1:0]     disp_data,
    output logic                  heartbeat
);

    localparam int NKEY   = 3;
    localparam int K_MODE = 0;
    localparam int K_STEP = 1;
    localparam int K_SEL  = 2;

    typedef enum logic [1:0] {
        HALT,
        STEP,
        RUN
    } state_t;

    logic [NKEY-1:0]   key_raw;
    logic [NKEY-1:0]   key_meta;
    logic [NKEY-1:0]   key_sync;
    logic [NKEY-1:0]   key_lvl;
    logic [NKEY-1:0]   key_press;
    logic [DBNC_W-1:0] dbnc_cnt [NKEY];

    logic              mode_press;
    logic              step_press;
    logic              sel_press;

    state_t            state;
    logic [DIV_W-1:0]  div;
    logic [DIV_W-1:0]  div_inc;
    logic              bp_skip;
    logic              bp_hit;
    logic [DIV_W:0]    hb_cnt;

    assign key_raw = {key_sel_n, key_step_n, key_mode_n};

    // Keys idle high, so synchronisers and debounced levels reset to "released".
    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta  <= '1;
            key_sync  <= '1;
            key_lvl   <= '1;
            key_press <= '0;
            for (int k = 0; k < NKEY; k++) begin
                dbnc_cnt[k] <= '0;
            end
        end else begin
            key_meta <= key_raw;
            key_sync <= key_meta;
            for (int k = 0; k < NKEY; k++) begin
                key_press[k] <= 1'b0;
                if (key_sync[k] == key_lvl[k]) begin
                    dbnc_cnt[k] <= '0;
                end else if (&dbnc_cnt[k]) begin
                    dbnc_cnt[k]  <= '0;
                    key_lvl[k]   <= key_sync[k];
                    // NOTE: non-blocking, so key_lvl here is still the pre-flip level;
                    // a press is the 1->0 flip only.
                    key_press[k] <= key_lvl[k];
                end else begin
                    dbnc_cnt[k] <= dbnc_cnt[k] + DBNC_W'(1);
                end
            end
        end
    end

    assign mode_press = key_press[K_MODE];
    assign step_press = key_press[K_STEP];
    assign sel_press  = key_press[K_SEL];

    assign div_inc = div + DIV_W'(1);
    assign bp_hit  = bp_en && (pc == bp_addr) && !bp_skip;

    // cpu_ce is registered one edge ahead so it is high exactly while div is all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HALT;
            div          <= '0;
            bp_skip      <= 1'b0;
            cpu_ce       <= 1'b0;
            halted_on_bp <= 1'b0;
        end else begin
            cpu_ce <= 1'b0;
            case (state)
                HALT: begin
                    if (mode_press) begin
                        state        <= RUN;
                        div          <= '0;
                        bp_skip      <= 1'b1;
                        halted_on_bp <= 1'b0;
                    end else if (step_press) begin
                        state        <= STEP;
                        cpu_ce       <= 1'b1;
                        halted_on_bp <= 1'b0;
                    end
                end
                STEP: begin
                    state <= HALT;
                end
                RUN: begin
                    if (mode_press) begin
                        state <= HALT;
                        div   <= '0;
                    end else begin
                        div <= div_inc;
                        if (&div_inc) begin
                            if (bp_hit) begin
                                state        <= HALT;
                                halted_on_bp <= 1'b1;
                            end else begin
                                cpu_ce  <= 1'b1;
                                bp_skip <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

    assign run = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_sel  <= '0;
            disp_data <= '0;
        end else begin
            if (sel_press) begin
                disp_sel <= (disp_sel == SEL_W'(NCH - 1)) ? '0 : disp_sel + SEL_W'(1);
            end
            disp_data <= ch_data[int'(disp_sel)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt <= '0;
        end else begin
            hb_cnt <= hb_cnt + (DIV_W + 1)'(1);
        end
    end

    assign heartbeat = hb_cnt[DIV_W];

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Self-checking bench for cpu_debug_ctrl: directed test-plan steps plus random key
// traffic, compared every cycle against an event-level reference model.
module tb_cpu_debug_ctrl;

    localparam int DIV_W  = 3;
    localparam int DBNC_W = 2;
    localparam int NCH    = 4;
    localparam int DATA_W = 16;
    localparam int PC_W   = 16;
    localparam int SEL_W  = 2;
    localparam int PERIOD = 1 << DIV_W;
    localparam int EV_LAT = 2 + (1 << DBNC_W);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  key_mode_n = 1'b1;
    logic                  key_step_n = 1'b1;
    logic                  key_sel_n = 1'b1;
    logic                  bp_en = 1'b0;
    logic [PC_W-1:0]       bp_addr = '0;
    logic [PC_W-1:0]       pc = '0;
    logic [NCH*DATA_W-1:0] ch_data = '0;
    logic                  cpu_ce;
    logic                  run;
    logic                  halted_on_bp;
    logic [SEL_W-1:0]      disp_sel;
    logic [DATA_W-1:0]     disp_data;
    logic                  heartbeat;

    cpu_debug_ctrl #(
        .DIV_W (DIV_W),
        .DBNC_W(DBNC_W),
        .NCH   (NCH),
        .DATA_W(DATA_W),
        .PC_W  (PC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_mode_n  (key_mode_n),
        .key_step_n  (key_step_n),
        .key_sel_n   (key_sel_n),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .ch_data     (ch_data),
        .cpu_ce      (cpu_ce),
        .run         (run),
        .halted_on_bp(halted_on_bp),
        .disp_sel    (disp_sel),
        .disp_data   (disp_data),
        .heartbeat   (heartbeat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ce_count = 0;
    int first_ce_cyc = -1;

    // Press events keyed by the cycle in which the debounced press becomes visible.
    bit ev_mode [int];
    bit ev_step [int];
    bit ev_sel  [int];

    bit              m_valid = 1'b0;
    bit              m_running = 1'b0;
    bit              m_skip = 1'b0;
    bit              m_bp = 1'b0;
    int              m_start = 0;
    int              m_step_cyc = -10;
    int              m_sel = 0;
    int              m_rst_cyc = 0;
    bit              e_ce, e_run, e_bp, e_hb;
    int              e_sel;
    logic [DATA_W-1:0] e_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs after edge cyc, from the inputs present at that edge.
    task automatic model_edge();
        bit mp, sp, lp;
        e_ce = 1'b0;
        if (rst) begin
            m_valid    = 1'b1;
            m_running  = 1'b0;
            m_skip     = 1'b0;
            m_bp       = 1'b0;
            m_sel      = 0;
            m_rst_cyc  = cyc;
            m_step_cyc = -10;
            e_data     = '0;
        end else if (m_valid) begin
            mp = ev_mode.exists(cyc - 1);
            sp = ev_step.exists(cyc - 1);
            lp = ev_sel.exists(cyc - 1);
            e_data = ch_data[m_sel*DATA_W +: DATA_W];
            if (lp) m_sel = (m_sel + 1) % NCH;
            if (m_step_cyc == cyc - 1) begin
                // the step cycle swallows any run/step press
            end else if (m_running) begin
                if (mp) begin
                    m_running = 1'b0;
                end else if ((cyc - m_start) % PERIOD == 0) begin
                    if (bp_en && pc == bp_addr && !m_skip) begin
                        m_running = 1'b0;
                        m_bp      = 1'b1;
                    end else begin
                        e_ce   = 1'b1;
                        m_skip = 1'b0;
                    end
                end
            end else if (mp) begin
                m_running = 1'b1;
                m_start   = cyc - 1;
                m_skip    = 1'b1;
                m_bp      = 1'b0;
            end else if (sp) begin
                e_ce       = 1'b1;
                m_step_cyc = cyc;
                m_bp       = 1'b0;
            end
        end
        e_run = m_running;
        e_bp  = m_bp;
        e_sel = m_sel;
        e_hb  = ((cyc - m_rst_cyc) % (2 * PERIOD)) >= PERIOD;
    endtask

    // One clock: model at the edge, compare at the falling edge, then act as the CPU.
    task automatic tick_clk();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        if (m_valid) begin
            check("cpu_ce", cpu_ce, e_ce);
            check("run", run, e_run);
            check("halted_on_bp", halted_on_bp, e_bp);
            check("disp_sel", disp_sel, e_sel);
            check("disp_data", disp_data, e_data);
            check("heartbeat", heartbeat, e_hb);
        end
        if (cpu_ce === 1'b1) begin
            ce_count++;
            if (first_ce_cyc < 0) first_ce_cyc = cyc;
            pc = pc + 16'd1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick_clk();
    endtask

    // Hold the chosen keys low for 'hold' cycles, then leave time for the release to settle.
    task automatic press(input bit m, input bit s, input bit l, input int hold, output int ev);
        int n = cyc;
        ev = n + EV_LAT;
        if (hold >= (1 << DBNC_W)) begin
            if (m) ev_mode[ev] = 1'b1;
            if (s) ev_step[ev] = 1'b1;
            if (l) ev_sel[ev] = 1'b1;
        end
        if (m) key_mode_n = 1'b0;
        if (s) key_step_n = 1'b0;
        if (l) key_sel_n = 1'b0;
        repeat (hold) tick_clk();
        key_mode_n = 1'b1;
        key_step_n = 1'b1;
        key_sel_n  = 1'b1;
        repeat (8) tick_clk();
    endtask

    initial begin
        int ev;
        int exp_sel [5] = '{1, 2, 3, 0, 1};
        logic [DATA_W-1:0] exp_dat [5] = '{16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hAAAA, 16'hBBBB};

        ch_data = {$urandom, $urandom};
        idle(3);
        rst = 1'b0;
        idle(2);
        check("reset_run", run, 1'b0);
        check("reset_sel", disp_sel, 2'd0);

        // free run, first pulse one period after the press event, glitch ignored
        first_ce_cyc = -1;
        press(1'b1, 1'b0, 1'b0, 10, ev);
        idle(30);
        check("t1_run", run, 1'b1);
        check("t1_first_ce", first_ce_cyc, ev + PERIOD);
        press(1'b1, 1'b0, 1'b0, 2, ev);
        check("t1_glitch_run", run, 1'b1);
        press(1'b1, 1'b0, 1'b0, 4, ev);
        check("t1_halt", run, 1'b0);

        // single steps in HALT, step presses ignored in RUN
        ce_count = 0;
        repeat (3) press(1'b0, 1'b1, 1'b0, 5, ev);
        check("t2_steps", ce_count, 3);
        check("t2_run", run, 1'b0);
        press(1'b1, 1'b0, 1'b0, 4, ev);
        ch_data = {$urandom, $urandom};
        repeat (2) press(1'b0, 1'b1, 1'b0, 5, ev);
        press(1'b1, 1'b0, 1'b0, 4, ev);

        // breakpoint at 0x0005
        pc = '0;
        bp_addr = 16'h0005;
        bp_en = 1'b1;
        ce_count = 0;
        press(1'b1, 1'b0, 1'b0, 4, ev);
        idle(50);
        check("t3_pulses", ce_count, 5);
        check("t3_pc", pc, 16'h0005);
        check("t3_hob", halted_on_bp, 1'b1);
        check("t3_run", run, 1'b0);
        ce_count = 0;
        press(1'b1, 1'b0, 1'b0, 4, ev);
        idle(4);
        check("t3_skip_ce", ce_count, 1);
        check("t3_skip_hob", halted_on_bp, 1'b0);
        check("t3_skip_pc", pc, 16'h0006);
        press(1'b1, 1'b0, 1'b0, 4, ev);
        pc = 16'h0004;
        press(1'b1, 1'b0, 1'b0, 4, ev);
        idle(20);
        check("t3_rehit_hob", halted_on_bp, 1'b1);
        check("t3_rehit_pc", pc, 16'h0005);

        // step off the breakpoint, then mode+step together
        ce_count = 0;
        press(1'b0, 1'b1, 1'b0, 4, ev);
        check("t4_step_ce", ce_count, 1);
        check("t4_step_hob", halted_on_bp, 1'b0);
        check("t4_step_pc", pc, 16'h0006);
        ce_count = 0;
        press(1'b1, 1'b1, 1'b0, 4, ev);
        check("t4_both_ce", ce_count, 0);
        check("t4_both_run", run, 1'b1);
        press(1'b1, 1'b0, 1'b0, 4, ev);
        bp_en = 1'b0;

        // display channel cycling
        ch_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        for (int i = 0; i < 5; i++) begin
            press(1'b0, 1'b0, 1'b1, 4, ev);
            check("t5_sel", disp_sel, exp_sel[i]);
            check("t5_data", disp_data, exp_dat[i]);
        end

        // reset one cycle before the first tick
        press(1'b1, 1'b0, 1'b0, 4, ev);
        idle(ev + PERIOD - 1 - cyc);
        rst = 1'b1;
        ce_count = 0;
        tick_clk();
        check("t6_ce", cpu_ce, 1'b0);
        check("t6_run", run, 1'b0);
        check("t6_hob", halted_on_bp, 1'b0);
        check("t6_sel", disp_sel, 2'd0);
        check("t6_data", disp_data, 16'h0000);
        check("t6_hb", heartbeat, 1'b0);
        rst = 1'b0;
        idle(20);
        check("t6_after_ce", ce_count, 0);

        // random key traffic against the model
        for (int i = 0; i < 40; i++) begin
            ch_data = {$urandom, $urandom};
            bp_en   = 1'($urandom_range(0, 1));
            bp_addr = pc + 16'($urandom_range(0, 3));
            press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 7), ev);
            idle($urandom_range(0, 20));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
